// File: rtl/seq101_pkg.sv
// Shared types and constants for the 101-preamble serial transmitter.
package seq101_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PRE  = 2'b01,
        DATA = 2'b10,
        GAP  = 2'b11
    } state_t;

    localparam logic [2:0]  PREAMBLE = 3'b101;
    localparam int unsigned PRE_LEN  = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq101_tx_piso_shift.sv
// Parallel-in serial-out shift register; MSB is always the next bit to send.
module piso_shift #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk) begin
        if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q << 1;
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/seq101_tx.sv
// Serial frame transmitter: preamble 1,0,1 then DATA_W payload bits MSB first,
// followed by IDLE_GAP forced-low cycles.
module seq101_tx
    import seq101_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned IDLE_GAP = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] DIN,
    input  logic              VALID,
    output logic              READY,
    output logic              A_OUT,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned CW = $clog2(DATA_W + 1);
    localparam int unsigned AW = $clog2(max_u(PRE_LEN, IDLE_GAP) + 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
    localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_LEN - 1);
    localparam logic [AW-1:0] GAP_LAST  = AW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    state_t        state, state_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic [AW-1:0] aux_cnt, aux_cnt_nxt;
    logic          a_nxt, busy_nxt, done_nxt;
    logic          load, shift, msb;

    piso_shift #(.W(DATA_W)) u_shift (
        .clk   (CLK),
        .load  (load),
        .shift (shift),
        .din   (DIN),
        .msb   (msb)
    );

    assign READY = (state == IDLE);

    // Outputs are registered: this block computes what A_OUT/BUSY/DONE
    // should show during the cycle that follows the coming edge.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        aux_cnt_nxt = aux_cnt;
        a_nxt       = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        load        = 1'b0;
        shift       = 1'b0;
        case (state)
            IDLE: begin
                if (VALID) begin
                    state_nxt   = PRE;
                    bit_cnt_nxt = '0;
                    aux_cnt_nxt = '0;
                    load        = 1'b1;
                    a_nxt       = PREAMBLE[2];
                    busy_nxt    = 1'b1;
                end
            end
            PRE: begin
                busy_nxt = 1'b1;
                if (aux_cnt == PRE_LAST) begin
                    state_nxt = DATA;
                    a_nxt     = msb;
                    shift     = 1'b1;
                    done_nxt  = (DATA_LAST == '0);
                end else begin
                    aux_cnt_nxt = aux_cnt + 1'b1;
                    a_nxt       = (aux_cnt == '0) ? PREAMBLE[1] : PREAMBLE[0];
                end
            end
            DATA: begin
                if (bit_cnt == DATA_LAST) begin
                    if (IDLE_GAP > 0) begin
                        state_nxt   = GAP;
                        aux_cnt_nxt = '0;
                        busy_nxt    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    a_nxt       = msb;
                    shift       = 1'b1;
                    busy_nxt    = 1'b1;
                    done_nxt    = (bit_cnt_nxt == DATA_LAST);
                end
            end
            GAP: begin
                if (aux_cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    aux_cnt_nxt = aux_cnt + 1'b1;
                    busy_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state   <= IDLE;
            bit_cnt <= '0;
            aux_cnt <= '0;
            A_OUT   <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            aux_cnt <= aux_cnt_nxt;
            A_OUT   <= a_nxt;
            BUSY    <= busy_nxt;
            DONE    <= done_nxt;
        end
    end

endmodule

// File: tb/tb_seq101_tx.sv
// Scoreboard bench for seq101_tx: expected {A_OUT,DONE,BUSY,READY} per cycle.
module tb_seq101_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       valid;
    logic       ready, a_out, busy, done;

    logic       din1;
    logic       valid1;
    logic       ready1, a_out1, busy1, done1;

    logic [3:0] sb[$];
    logic [3:0] exp_v;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    seq101_tx #(.DATA_W(8), .IDLE_GAP(1)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .DIN     (din),
        .VALID   (valid),
        .READY   (ready),
        .A_OUT   (a_out),
        .BUSY    (busy),
        .DONE    (done)
    );

    seq101_tx #(.DATA_W(1), .IDLE_GAP(0)) dut1 (
        .CLK     (clk),
        .RESET_N (rst_n),
        .DIN     (din1),
        .VALID   (valid1),
        .READY   (ready1),
        .A_OUT   (a_out1),
        .BUSY    (busy1),
        .DONE    (done1)
    );

    // Entries are {a_out, done, busy, ready}; one gap cycle then one idle cycle.
    function automatic void push_frame(input logic [7:0] d);
        sb.push_back(4'b1010);
        sb.push_back(4'b0010);
        sb.push_back(4'b1010);
        for (int i = 7; i >= 0; i--) begin
            sb.push_back({d[i], (i == 0), 1'b1, 1'b0});
        end
        sb.push_back(4'b0010);
        sb.push_back(4'b0001);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        valid = 1'b1;
        din   = 8'hA5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_out, done, busy, ready} !== 4'b0001) begin
                n_fail++;
                $display("FAIL reset[%0d]: got %b want 0001", i, {a_out, done, busy, ready});
            end
        end
        rst_n = 1'b1;
        valid = 1'b0;
        for (int i = 0; i < 3; i++) sb.push_back(4'b0001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_v = sb.pop_front();
            n_checks++;
            if ({a_out, done, busy, ready} !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got %b want %b", i, {a_out, done, busy, ready}, exp_v);
            end
        end
    endtask

    task automatic test_frame(input logic [7:0] d, input int exp_hits);
        logic [2:0] hist = '0;
        int         hits = 0;
        int         n;
        din   = d;
        valid = 1'b1;
        push_frame(d);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) valid = 1'b0;
            exp_v = sb.pop_front();
            hist  = {hist[1:0], a_out};
            if (hist == 3'b101) hits++;
            n_checks++;
            if ({a_out, done, busy, ready} !== exp_v) begin
                n_fail++;
                $display("FAIL frame_%h[%0d]: got %b want %b", d, i, {a_out, done, busy, ready}, exp_v);
            end
        end
        n_checks++;
        if (hits !== exp_hits) begin
            n_fail++;
            $display("FAIL detect_%h: got %0d hits want %0d", d, hits, exp_hits);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        din   = 8'hFF;
        valid = 1'b1;
        push_frame(8'hFF);
        push_frame(8'h00);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0)  din = 8'h00;
            if (i == 13) valid = 1'b0;
            exp_v = sb.pop_front();
            n_checks++;
            if ({a_out, done, busy, ready} !== exp_v) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %b want %b", i, {a_out, done, busy, ready}, exp_v);
            end
        end
    endtask

    task automatic test_din_change();
        int n;
        din   = 8'h3C;
        valid = 1'b1;
        push_frame(8'h3C);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                valid = 1'b0;
                din   = 8'hFF;
            end
            exp_v = sb.pop_front();
            n_checks++;
            if ({a_out, done, busy, ready} !== exp_v) begin
                n_fail++;
                $display("FAIL din_change[%0d]: got %b want %b", i, {a_out, done, busy, ready}, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        din   = 8'h5A;
        valid = 1'b1;
        push_frame(8'h5A);
        while (sb.size() > 8) void'(sb.pop_back());
        sb.push_back(4'b0001);
        sb.push_back(4'b0001);
        sb.push_back(4'b0001);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) valid = 1'b0;
            exp_v = sb.pop_front();
            n_checks++;
            if ({a_out, done, busy, ready} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_mid[%0d]: got %b want %b", i, {a_out, done, busy, ready}, exp_v);
            end
            if (i == 7) rst_n = 1'b0;
            if (i == 8) rst_n = 1'b1;
        end
    endtask

    task automatic test_narrow();
        int n;
        din1   = 1'b1;
        valid1 = 1'b1;
        for (int p = 0; p < 3; p++) begin
            sb.push_back(4'b1010);
            sb.push_back(4'b0010);
            sb.push_back(4'b1010);
            sb.push_back(4'b1110);
            sb.push_back(4'b0001);
        end
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == n - 1) valid1 = 1'b0;
            exp_v = sb.pop_front();
            n_checks++;
            if ({a_out1, done1, busy1, ready1} !== exp_v) begin
                n_fail++;
                $display("FAIL narrow[%0d]: got %b want %b", i, {a_out1, done1, busy1, ready1}, exp_v);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        valid  = 1'b0;
        din    = '0;
        valid1 = 1'b0;
        din1   = 1'b0;
        test_reset();
        test_frame(8'hA5, 3);
        test_back_to_back();
        test_din_change();
        test_reset_mid();
        test_frame(8'h81, 1);
        test_narrow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
